// File: rtl/mdu_param_pkg.sv
// mdu_param_pkg: op-code constants, op classification and latency checks.
// Accumulate ops (codes 7..10) exist only when MDU_PARAM_MADD_EN is defined.
package mdu_param_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    localparam int CNT_W = 4;

    function automatic logic is_mul(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_acc(input logic [3:0] op);
`ifdef MDU_PARAM_MADD_EN
        return (op >= OP_MADD) && (op <= OP_MSUBU);
`else
        return (op == OP_MADD) && 1'b0;
`endif
    endfunction

    // Signed flavour of multiply, divide and accumulate
    function automatic logic is_sgn(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV) ||
               (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    function automatic logic is_sub(input logic [3:0] op);
        return (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    // Latency must fit the 4-bit countdown and be nonzero
    function automatic bit lat_ok(input int lat);
        return (lat >= 1) && (lat <= 15);
    endfunction

endpackage

// File: rtl/mdu_param_divcore.sv
// mdu_param_divcore: combinational signed/unsigned divider.
// Divisor 0 passes HI/LO through; signed MIN/-1 yields LO=MIN, HI=0.
module mdu_param_divcore #(
    parameter int WIDTH = 32
) (
    input  logic             sgn_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] r_o
);

    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;

    // Magnitude divide, then restore signs (truncate toward zero)
    always_comb begin
        a_neg = sgn_i & a_i[WIDTH-1];
        b_neg = sgn_i & b_i[WIDTH-1];
        a_mag = a_neg ? -a_i : a_i;
        b_mag = b_neg ? -b_i : b_i;
        q_mag = '0;
        r_mag = '0;
        q_o   = lo_i;
        r_o   = hi_i;
        if (b_i != '0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
            if (sgn_i && (a_i == MIN) && (b_i == '1)) begin
                q_o = MIN;
                r_o = '0;
            end else begin
                q_o = (a_neg ^ b_neg) ? -q_mag : q_mag;
                r_o = a_neg ? -r_mag : r_mag;
            end
        end
    end

endmodule

// File: rtl/mdu_param.sv
// mdu_param: HI/LO multiply/divide unit with countdown latency model.
// Define MDU_PARAM_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (codes 7..10).
module mdu_param
    import mdu_param_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_d1,
    input  logic [WIDTH-1:0] i_d2,
    input  logic             i_cancel,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    if (!lat_ok(MUL_LAT) || !lat_ok(DIV_LAT)) begin : g_lat_bad
        $error("mdu_param: MUL_LAT/DIV_LAT must be in 1..15");
    end

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   phi_q, phi_d;
    logic [WIDTH-1:0]   plo_q, plo_d;
    logic               accept;
    logic               sgn;
    logic [2*WIDTH-1:0] ext1, ext2, prod;
    logic [WIDTH-1:0]   dq, dr;
`ifdef MDU_PARAM_MADD_EN
    logic [2*WIDTH-1:0] acc;
`endif

    assign o_busy = (cnt_q != '0);
    assign o_hi   = hi_q;
    assign o_lo   = lo_q;
    assign accept = i_start & ~i_cancel & ~o_busy;
    assign sgn    = is_sgn(i_op);

    mdu_param_divcore #(
        .WIDTH(WIDTH)
    ) u_div (
        .sgn_i(sgn),
        .a_i  (i_d1),
        .b_i  (i_d2),
        .hi_i (hi_q),
        .lo_i (lo_q),
        .q_o  (dq),
        .r_o  (dr)
    );

    // Full-width product of sign- or zero-extended operands
    always_comb begin
        ext1 = {{WIDTH{i_d1[WIDTH-1] & sgn}}, i_d1};
        ext2 = {{WIDTH{i_d2[WIDTH-1] & sgn}}, i_d2};
        prod = ext1 * ext2;
`ifdef MDU_PARAM_MADD_EN
        acc  = is_sub(i_op) ? ({hi_q, lo_q} - prod)
                            : ({hi_q, lo_q} + prod);
`endif
    end

    // Countdown/commit while busy, otherwise accept a new op
    always_comb begin
        cnt_d = cnt_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        phi_d = phi_q;
        plo_d = plo_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                hi_d = phi_q;
                lo_d = plo_q;
            end
        end else if (accept) begin
            unique case (1'b1)
                is_mul(i_op): begin
                    cnt_d          = MUL_CNT;
                    {phi_d, plo_d} = prod;
                end
                is_div(i_op): begin
                    cnt_d = DIV_CNT;
                    phi_d = dr;
                    plo_d = dq;
                end
`ifdef MDU_PARAM_MADD_EN
                is_acc(i_op): begin
                    cnt_d          = MUL_CNT;
                    {phi_d, plo_d} = acc;
                end
`endif
                (i_op == OP_MTHI): hi_d = i_d1;
                (i_op == OP_MTLO): lo_d = i_d1;
                default: ;
            endcase
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            phi_q <= '0;
            plo_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            phi_q <= phi_d;
            plo_q <= plo_d;
        end
    end

endmodule

// File: doc/mdu_param.md
Name: mdu_param

Overview:
- Parametrised successor to the pipeline's multiply/divide unit; instantiated in the E stage.
- Accepts one HI/LO operation per start and models MULT/DIV latency with a countdown.
- Exposes busy to the hazard unit and HI/LO to the MFHI/MFLO path.
- Adds generic width, independent per-class latencies, an in-cycle interrupt cancel and divide corner-case rules.

Parameters:
- WIDTH, 32, operand and HI/LO register width.
- MUL_LAT, 5, cycles busy for multiply-class ops; legal range 1..15.
- DIV_LAT, 10, cycles busy for divide-class ops; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- i_start  in  1  E-stage instruction is an HI/LO op this cycle.
- i_op  in  4  operation code (constants in mdu_param_pkg).
- i_d1  in  WIDTH  forwarded rs value.
- i_d2  in  WIDTH  forwarded rt value.
- i_cancel  in  1  CP0 interrupt request; suppresses a start in the same cycle.
- o_busy  out  1  operation in flight.
- o_hi  out  WIDTH  HI register.
- o_lo  out  WIDTH  LO register.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: o_hi=0, o_lo=0, o_busy=0, counter=0, pending results=0.
- Op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
- Codes 7..10 are reserved for the optional feature; codes 11..15 are treated as NONE.
- Accept condition: i_start & ~i_cancel & ~o_busy.
- Start while busy: ignored; state unchanged. The hazard unit guarantees this never happens; the bench asserts on it.
- MTHI/MTLO: written from i_d1 at the accepting edge; o_busy stays 0; the new value is visible the next cycle.
- MULT/MULTU: full 2*WIDTH product computed from operands latched at accept and held in pending {hi,lo}. Counter loads MUL_LAT.
- DIV/DIVU: LO=quotient, HI=remainder. Counter loads DIV_LAT.
  - Signed division truncates toward zero; remainder takes the dividend's sign.
- Divide corner cases:
  - Divisor 0: HI and LO unchanged; busy timing still applies.
  - Signed MIN/-1: LO=MIN, HI=0.
- Countdown:
  - o_busy = (counter != 0); counter decrements each cycle.
  - On the edge where counter goes 1->0, pending values commit to o_hi/o_lo.
  - Busy is high for exactly LAT cycles; new HI/LO is visible in the first cycle busy is low.
- Cancel: affects only the same-cycle start. An operation already in flight always completes, because its instruction has already committed.
- Reset mid-operation: counter cleared and the pending result discarded at that edge.
- Back-to-back: a start presented the cycle busy falls is accepted and reads the just-committed HI/LO; this matters for accumulate ops.
- Outputs are registered only; there is no combinational path from i_* to o_*.

Optional Feature:
- Macro: MDU_PARAM_MADD_EN.
- Defined: codes 7..10 = MADD, MADDU, MSUB, MSUBU.
  - {HI,LO} ± signed/unsigned product, modulo 2^(2*WIDTH), using HI/LO as of the accept cycle.
  - Latency is MUL_LAT.
- Undefined: codes 7..10 are treated as NONE (no busy, no state change), and the accumulate adder is not synthesised.

Decomposition:
- Package mdu_param_pkg: op-code constants, is_mul/is_div/is_acc classification functions, and LAT range checks.
- One sub-module: mdu_param_divcore, a combinational signed/unsigned divider parametrised by WIDTH that applies the zero and MIN/-1 rules.
- The top holds the counter, pending registers and HI/LO.

Test Plan:
- MULT 0xFFFFFFFF × 0x00000002 (signed), MUL_LAT=5 → busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- DIV -7 / 2 then DIVU 7 / 0, DIV_LAT=10:
  - First op: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Second op: HI/LO unchanged after 10 busy cycles.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI 0x1234 → o_busy never rises; o_hi=0x1234 on the next cycle. MTLO issued together with i_cancel=1 → LO unchanged.
- MULT started, then reset asserted in busy cycle 3 → next cycle busy=0, HI=LO=0; i_start asserted while busy → no effect.
- With MDU_PARAM_MADD_EN: HI=0, LO=0xFFFFFFFF, then MADDU 1×1 → HI=1, LO=0. Without the macro, the same op code leaves HI/LO unchanged and busy low.
